stopwatch_counter: RTL and testbench
====================================

# stopwatch_counter

- Consumer end of the 100 Hz timebase: counts single-cycle `tick_100Hz` enable pulses into a BCD mm:ss.cc stopwatch value.
- The pulses come from the clock divider; everything runs on the 50 MHz clock, with no clock derived from the divider.
- Contains the run/pause/clear control FSM and an optional lap-hold display freeze.
- Drives the seven-segment display mux with six registered BCD digits.

## Interface
- `MIN_MAX`, default 59: highest minute value before wrap; legal range 1..99.
- `CLK_50MHz`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `tick_100Hz`  in  1  one-cycle enable pulse, nominally every 500 000 cycles.
- `start_stop`  in  1  one-cycle debounced button pulse.
- `clear`  in  1  one-cycle pulse; acts only when not counting.
- `lap`  in  1  one-cycle pulse; ignored when `STOPWATCH_LAP_EN` is undefined.
- `disp_digits`  out  24  BCD {min_t, min_u, sec_t, sec_u, cs_t, cs_u}, 4 bits each, MSB = min_t.
- `running`  out  1  high in RUN and LAP.
- `overflow`  out  1  one-cycle pulse when the count wraps.

## Operation
- FSM states: IDLE, RUN, PAUSE, LAP.
- IDLE:
  - `start_stop` -> RUN.
  - `clear` -> stays IDLE.
- RUN:
  - `start_stop` -> PAUSE.
  - `lap` -> LAP; display freezes at the current count.
  - `clear` ignored.
- LAP:
  - `lap` -> RUN; display goes live again.
  - `start_stop` -> PAUSE; display goes live, showing the counter value.
  - `clear` ignored.
- PAUSE:
  - `start_stop` -> RUN.
  - `clear` -> IDLE with the counter zeroed.
- Same-cycle priority: `clear` (where legal) > `start_stop` > `lap`.
- Counting:
  - Counter increments by 1 cs on any cycle with `tick_100Hz`=1 while the registered state is RUN or LAP.
  - The counter keeps running in LAP.
- BCD carry chain:
  - cs_u 9->0 carries into cs_t.
  - cs_t 9->0 carries into sec_u.
  - sec_u 9->0 carries into sec_t.
  - sec_t 5->0 carries into minutes.
  - Minutes count 00..`MIN_MAX` in BCD.
- Wrap: at `MIN_MAX`:59.99 the next tick goes to 00:00.00 and pulses `overflow`; counting continues.
- Digit rules: no digit ever holds a non-BCD value; ten-digit limits are 9, 5, 9, `MIN_MAX`/10.
- `disp_digits` shows the live counter except in LAP, where it holds the lap snapshot.

## Timing
- Reset values:
  - state = IDLE.
  - `disp_digits` = 24'h000000.
  - `running` = 0, `overflow` = 0.
  - lap snapshot = 0.
- All outputs are registered.
- A tick at edge N shows on `disp_digits` after edge N (1-cycle latency). `overflow` is high in the same cycle as the wrapped digits.
- A state change takes effect at the edge after the pulse. `running` follows the state, with no extra delay.
- Tick in the same cycle as `start_stop`:
  - From IDLE or PAUSE: the tick is not counted.
  - From RUN: the tick is counted, then the FSM pauses.
- `lap` coincident with a tick in RUN: the snapshot holds the pre-increment value.
- Reset asserted mid-count clears everything immediately (asynchronous). Counting resumes only after deassertion plus a `start_stop`.
- Back-to-back ticks on consecutive cycles are each counted; the block does not assume a minimum spacing.

## Configuration
- `STOPWATCH_LAP_EN` defined:
  - LAP state and snapshot register are present.
  - `lap` behaves as specified above.
- Undefined:
  - No LAP state and no snapshot register.
  - `lap` is ignored; `disp_digits` is always live.
  - All other behaviour is identical.

## Structure
- Shared package `stopwatch_pkg`:
  - FSM state encoding (IDLE=0, RUN=1, PAUSE=2, LAP=3).
  - Digit limit constants (CS_MAX=9, SEC_T_MAX=5).
  - BCD digit width 4.
- Sub-module `bcd_digit_counter`:
  - Ports: `en`, `clr`, limit, `digit`, `carry_out`.
  - Four instances cover cs_u, cs_t, sec_u and sec_t.
  - The minute pair is handled in the top, to apply `MIN_MAX`.

## Test plan
- Reset, then `start_stop`, then 150 ticks -> `disp_digits`=24'h000150, `running`=1.
- Run to 00:59.99, then 1 tick -> 24'h010000; at 59:59.99 (`MIN_MAX`=59), 1 tick -> 24'h000000 with a one-cycle `overflow`.
- Run 25 ticks, `start_stop`, 10 more ticks -> held at 24'h000025. Then `clear` with `start_stop` in the same cycle -> IDLE, 24'h000000, `running`=0.
- With `STOPWATCH_LAP_EN`: 30 ticks, `lap`, 20 ticks -> display 24'h000030. Then `lap` -> 24'h000050 on the next cycle.
- Tick coincident with the `start_stop` that leaves IDLE -> display stays 24'h000000. Tick coincident with the `start_stop` that pauses from 24'h000009 -> display 24'h000010.
- Assert `reset` mid-count at 24'h012345 -> outputs zero without waiting for a clock edge. Ticks after deassertion, with no `start_stop`, leave the display at 24'h000000.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
//   Shared definitions for the stopwatch counter slice.
//   - state_t   : control FSM encoding (IDLE=0, RUN=1, PAUSE=2, LAP=3)
//   - DIGIT_W   : BCD digit width
//   - CS_MAX    : upper limit of the centisecond digits and of the seconds units digit
//   - SEC_T_MAX : upper limit of the seconds tens digit
//   - BCD_MAX   : upper limit of the minutes units digit below the wrap point
package stopwatch_pkg;

  localparam int unsigned DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] CS_MAX    = 4'd9;
  localparam logic [DIGIT_W-1:0] SEC_T_MAX = 4'd5;
  localparam logic [DIGIT_W-1:0] BCD_MAX   = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

endpackage

// File: rtl/bcd_digit_counter.sv
// bcd_digit_counter
//   One BCD digit that counts 0..limit and wraps to 0.
//   Ports:
//     clk       in   system clock, rising edge
//     rst       in   asynchronous active-high reset
//     en        in   advance the digit this cycle
//     clr       in   synchronous clear to 0 (wins over en)
//     limit     in   highest value the digit holds before wrapping
//     digit     out  registered digit value
//     carry_out out  high when en is set and the digit is about to wrap
module bcd_digit_counter
  import stopwatch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic [DIGIT_W-1:0] limit,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry_out
);

  // Combinational so a whole carry chain ripples within one tick.
  assign carry_out = en && (digit == limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit <= '0;
    end else if (clr) begin
      digit <= '0;
    end else if (en) begin
      digit <= (digit == limit) ? '0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// stopwatch_counter
//   Counts tick_100Hz enable pulses into a BCD mm:ss.cc value under a
//   run/pause/clear control FSM. Optional lap-hold display freeze is
//   compiled in when the macro STOPWATCH_LAP_EN is defined.
//   Parameters:
//     MIN_MAX     highest minute value before wrap (1..99)
//   Ports:
//     CLK_50MHz   in   system clock, rising edge
//     reset       in   asynchronous active-high reset
//     tick_100Hz  in   one-cycle count enable
//     start_stop  in   one-cycle run/pause toggle
//     clear       in   one-cycle clear, honoured in IDLE and PAUSE only
//     lap         in   one-cycle lap toggle (only with STOPWATCH_LAP_EN)
//     disp_digits out  {min_t, min_u, sec_t, sec_u, cs_t, cs_u}
//     running     out  high in RUN and LAP
//     overflow    out  one-cycle pulse alongside the wrapped digits
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned MIN_MAX = 59
) (
  input  logic        CLK_50MHz,
  input  logic        reset,
  input  logic        tick_100Hz,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  output logic [23:0] disp_digits,
  output logic        running,
  output logic        overflow
);

  localparam logic [DIGIT_W-1:0] MIN_T_MAX = 4'(MIN_MAX / 10);
  localparam logic [DIGIT_W-1:0] MIN_U_MAX = 4'(MIN_MAX % 10);

  state_t state, state_next;

  logic count_en, count_clr;
  logic [DIGIT_W-1:0] cs_u, cs_t, sec_u, sec_t, min_u, min_t;
  logic cs_u_carry, cs_t_carry, sec_u_carry, sec_t_carry;
  logic min_wrap;
  logic [23:0] live;

  // The registered state gates counting, so a tick coincident with the
  // start_stop that leaves IDLE/PAUSE is dropped, while one coincident
  // with the start_stop that pauses from RUN is still counted.
  assign count_en  = tick_100Hz && ((state == RUN) || (state == LAP));
  assign count_clr = clear && (state == PAUSE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_stop && !clear) state_next = RUN;
      end
      RUN: begin
        if (start_stop) state_next = PAUSE;
`ifdef STOPWATCH_LAP_EN
        else if (lap)   state_next = LAP;
`endif
      end
      PAUSE: begin
        if (clear)           state_next = IDLE;
        else if (start_stop) state_next = RUN;
      end
`ifdef STOPWATCH_LAP_EN
      LAP: begin
        if (start_stop) state_next = PAUSE;
        else if (lap)   state_next = RUN;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK_50MHz or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      running <= 1'b0;
    end else begin
      state   <= state_next;
      running <= (state_next == RUN) || (state_next == LAP);
    end
  end

  bcd_digit_counter u_cs_u (
    .clk(CLK_50MHz), .rst(reset), .en(count_en), .clr(count_clr),
    .limit(CS_MAX), .digit(cs_u), .carry_out(cs_u_carry)
  );

  bcd_digit_counter u_cs_t (
    .clk(CLK_50MHz), .rst(reset), .en(cs_u_carry), .clr(count_clr),
    .limit(CS_MAX), .digit(cs_t), .carry_out(cs_t_carry)
  );

  bcd_digit_counter u_sec_u (
    .clk(CLK_50MHz), .rst(reset), .en(cs_t_carry), .clr(count_clr),
    .limit(CS_MAX), .digit(sec_u), .carry_out(sec_u_carry)
  );

  bcd_digit_counter u_sec_t (
    .clk(CLK_50MHz), .rst(reset), .en(sec_u_carry), .clr(count_clr),
    .limit(SEC_T_MAX), .digit(sec_t), .carry_out(sec_t_carry)
  );

  // Minutes wrap at MIN_MAX rather than at a fixed per-digit limit, so the
  // pair is handled here as one two-digit BCD counter.
  assign min_wrap = sec_t_carry && (min_t == MIN_T_MAX) && (min_u == MIN_U_MAX);

  always_ff @(posedge CLK_50MHz or posedge reset) begin
    if (reset) begin
      min_u    <= '0;
      min_t    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= min_wrap;
      if (count_clr || min_wrap) begin
        min_u <= '0;
        min_t <= '0;
      end else if (sec_t_carry) begin
        if (min_u == BCD_MAX) begin
          min_u <= '0;
          min_t <= min_t + 4'd1;
        end else begin
          min_u <= min_u + 4'd1;
        end
      end
    end
  end

  assign live = {min_t, min_u, sec_t, sec_u, cs_t, cs_u};

`ifdef STOPWATCH_LAP_EN
  logic [23:0] snapshot;

  // Captured on the RUN->LAP edge from the pre-increment digits.
  always_ff @(posedge CLK_50MHz or posedge reset) begin
    if (reset) begin
      snapshot <= '0;
    end else if ((state == RUN) && (state_next == LAP)) begin
      snapshot <= live;
    end
  end

  assign disp_digits = (state == LAP) ? snapshot : live;
`else
  logic unused_lap;
  assign unused_lap  = lap;
  assign disp_digits = live;
`endif

endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter
//   Directed bench for stopwatch_counter built with MIN_MAX=10 so the wrap
//   (10:59.99 -> 00:00.00) and the minute tens carry are both reachable.
//   Lap expectations follow STOPWATCH_LAP_EN.
module tb_stopwatch_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic        ss;
  logic        clr;
  logic        lp;
  logic [23:0] disp;
  logic        running;
  logic        overflow;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  stopwatch_counter #(.MIN_MAX(10)) dut (
    .CLK_50MHz  (clk),
    .reset      (reset),
    .tick_100Hz (tick),
    .start_stop (ss),
    .clear      (clr),
    .lap        (lp),
    .disp_digits(disp),
    .running    (running),
    .overflow   (overflow)
  );

  task automatic check_eq(input string tag, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock with the given pulses held, then all pulses dropped.
  task automatic cyc(input logic s, input logic c, input logic l, input logic t);
    ss = s; clr = c; lp = l; tick = t;
    @(posedge clk);
    #1;
    ss = 1'b0; clr = 1'b0; lp = 1'b0; tick = 1'b0;
  endtask

  // Back-to-back ticks on n consecutive cycles.
  task automatic ticks(input int unsigned n);
    tick = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; ss = 1'b0; clr = 1'b0; lp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("rst_disp", disp, 24'h000000);
    check_eq("rst_run",  24'(running), 24'd0);
    check_eq("rst_ovf",  24'(overflow), 24'd0);

    // Tick with the start_stop leaving IDLE is dropped.
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("idle_ss_tick", disp, 24'h000000);
    check_eq("idle_ss_run",  24'(running), 24'd1);
    ticks(9);
    check_eq("nine", disp, 24'h000009);
    // Tick with the start_stop pausing from RUN is counted.
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("pause_tick", disp, 24'h000010);
    check_eq("pause_run",  24'(running), 24'd0);
    ticks(10);
    check_eq("pause_hold", disp, 24'h000010);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("clear_pause", disp, 24'h000000);

    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(150);
    check_eq("cnt150",     disp, 24'h000150);
    check_eq("cnt150_run", 24'(running), 24'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("clear_in_run",     disp, 24'h000150);
    check_eq("clear_in_run_run", 24'(running), 24'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("clr_ss_pause",     disp, 24'h000000);
    check_eq("clr_ss_pause_run", 24'(running), 24'd0);

    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(25);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(10);
    check_eq("hold25",     disp, 24'h000025);
    check_eq("hold25_run", 24'(running), 24'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("clr_ss",     disp, 24'h000000);
    check_eq("clr_ss_run", 24'(running), 24'd0);
    ticks(3);
    check_eq("idle_ticks", disp, 24'h000000);

    // Lap freeze (or lap ignored in the default build).
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(30);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(20);
`ifdef STOPWATCH_LAP_EN
    check_eq("lap_freeze", disp, 24'h000030);
`else
    check_eq("lap_freeze", disp, 24'h000050);
`endif
    check_eq("lap_run", 24'(running), 24'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("lap_live", disp, 24'h000050);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
`ifdef STOPWATCH_LAP_EN
    check_eq("lap_tick_snap", disp, 24'h000050);
`else
    check_eq("lap_tick_snap", disp, 24'h000051);
`endif
    ticks(4);
`ifdef STOPWATCH_LAP_EN
    check_eq("lap_keeps_cnt", disp, 24'h000050);
`else
    check_eq("lap_keeps_cnt", disp, 24'h000055);
`endif
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("lap_to_pause",     disp, 24'h000055);
    check_eq("lap_to_pause_run", 24'(running), 24'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);

    // Carry chain and wrap at 10:59.99.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(6000);
    check_eq("one_min", disp, 24'h010000);
    ticks(54000);
    check_eq("ten_min", disp, 24'h100000);
    ticks(5999);
    check_eq("max",     disp, 24'h105999);
    check_eq("max_ovf", 24'(overflow), 24'd0);
    ticks(1);
    check_eq("wrap",     disp, 24'h000000);
    check_eq("wrap_ovf", 24'(overflow), 24'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("ovf_pulse", 24'(overflow), 24'd0);
    ticks(1);
    check_eq("after_wrap", disp, 24'h000001);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-count.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(8345);
    check_eq("pre_reset", disp, 24'h012345);
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_rst_disp", disp, 24'h000000);
    check_eq("async_rst_run",  24'(running), 24'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    ticks(5);
    check_eq("post_rst_disp", disp, 24'h000000);
    check_eq("post_rst_run",  24'(running), 24'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
